// File: rtl/onchip_mem_loader_pkg.sv
// Shared types and default sizes for the on-chip memory stream loader.
// Optional read-back verify pass is enabled by ONCHIP_MEM_LOADER_VERIFY_EN.
package onchip_mem_loader_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 14;
   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned LEN_W_DEFAULT  = 15;
   localparam int unsigned MEM_DEPTH      = 1 << ADDR_W_DEFAULT;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StFlush,
      StVrd,
      StVdrain,
      StDone
   } loader_state_e;

endpackage

// File: rtl/onchip_mem_stream_loader_if.sv
// Stream sink plus Avalon-style RAM port of the loader.
// master: the loader side; slave: the stream source / RAM side.
interface onchip_mem_stream_loader_if
   import onchip_mem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT
);

   logic [DATA_W-1:0]   snk_data;
   logic                snk_valid;
   logic                snk_ready;
   logic [ADDR_W-1:0]   mem_address;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic                mem_chipselect;
   logic                mem_write;
   logic [DATA_W-1:0]   mem_writedata;
   logic [DATA_W-1:0]   mem_readdata;

   modport master (
      input  snk_data, snk_valid, mem_readdata,
      output snk_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
   );

   modport slave (
      output snk_data, snk_valid, mem_readdata,
      input  snk_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
   );

endinterface

// File: rtl/onchip_mem_loader_addr_gen.sv
// Base-plus-offset word address counter with wrap, shared by the write and verify passes.
// tc_o goes high once the offset for word length-1 has been stepped past.
module onchip_mem_loader_addr_gen
   import onchip_mem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned LEN_W  = LEN_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  length_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o,
   output logic              tc_o
);

   logic [LEN_W-1:0] count_q, count_d;
   logic             tc_q, tc_d;

   always_comb begin
      count_d = count_q;
      tc_d    = tc_q;
      if (load_i) begin
         count_d = '0;
         tc_d    = 1'b0;
      end else if (step_i) begin
         count_d = count_q + LEN_W'(1);
         tc_d    = tc_q | last_o;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   // Truncating add gives the 2^ADDR_W wrap for free.
   assign addr_o = base_i + count_q[ADDR_W-1:0];
   assign last_o = (count_q == length_i - LEN_W'(1));
   assign tc_o   = tc_q;

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Writes a valid/ready word stream into consecutive on-chip RAM words from a programmed base.
// Define ONCHIP_MEM_LOADER_VERIFY_EN to add a read-back checksum pass that drives error_o.
module onchip_mem_stream_loader
   import onchip_mem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned LEN_W  = LEN_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start_i,
   input  logic [ADDR_W-1:0]         base_addr_i,
   input  logic [LEN_W-1:0]          length_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [LEN_W-1:0]          words_written_o,
   output logic                      error_o,
   onchip_mem_stream_loader_if.master bus
);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] base_q, mem_addr_q, mem_addr_d, gen_addr;
   logic [LEN_W-1:0]  len_q, ww_q;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
   logic              snk_ready, hs, accept;
   logic              gen_load, gen_step, gen_last, gen_tc;

   assign accept = (state_q == StIdle) & start_i;
   assign hs     = snk_ready & bus.snk_valid;

   onchip_mem_loader_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (gen_load),
      .step_i   (gen_step),
      .base_i   (base_q),
      .length_i (len_q),
      .addr_o   (gen_addr),
      .last_o   (gen_last),
      .tc_o     (gen_tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start_i) state_d = (length_i == '0) ? StDone : StWrite;
         StWrite:  if (hs && gen_last) state_d = StFlush;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
         StFlush:  state_d = StVrd;
         StVrd:    if (gen_tc) state_d = StVdrain;
         StVdrain: state_d = StDone;
`else
         StFlush:  state_d = StDone;
`endif
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != StIdle);
      done_o      = (state_q == StDone);
      snk_ready   = 1'b0;
      mem_cs_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      gen_load    = 1'b0;
      gen_step    = 1'b0;
      unique case (state_q)
         StIdle: gen_load = start_i;
         StWrite: begin
            snk_ready = 1'b1;
            if (bus.snk_valid) begin
               mem_cs_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = gen_addr;
               mem_wdata_d = bus.snk_data;
               // Rewind on the last word so the verify pass starts again at base.
               gen_load    = gen_last;
               gen_step    = ~gen_last;
            end
         end
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
         // Reads are issued one cycle ahead so each VRD cycle has one on the bus.
         StFlush, StVrd: begin
            if (!gen_tc) begin
               mem_cs_d   = 1'b1;
               mem_addr_d = gen_addr;
               gen_step   = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q      <= '0;
         len_q       <= '0;
         ww_q        <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         if (accept) begin
            base_q <= base_addr_i;
            len_q  <= length_i;
         end
         if (accept) begin
            ww_q <= '0;
         end else if (hs) begin
            ww_q <= ww_q + LEN_W'(1);
         end
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
   logic [DATA_W-1:0] wr_sum_q, rd_sum_q, rd_sum_nxt;
   logic              rdv_q, err_q;

   // RAM q is valid the cycle after a read address was on the bus.
   assign rd_sum_nxt = rd_sum_q + (rdv_q ? bus.mem_readdata : '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_sum_q <= '0;
         rd_sum_q <= '0;
         rdv_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rdv_q <= mem_cs_q & ~mem_we_q;
         if (accept) begin
            wr_sum_q <= '0;
            rd_sum_q <= '0;
            err_q    <= 1'b0;
         end else begin
            if (hs) wr_sum_q <= wr_sum_q + bus.snk_data;
            rd_sum_q <= rd_sum_nxt;
            if (state_q == StVdrain) err_q <= (rd_sum_nxt != wr_sum_q);
         end
      end
   end

   assign error_o = err_q;
`else
   logic unused_verify;
   assign unused_verify = ^{gen_tc, bus.mem_readdata};
   assign error_o       = 1'b0;
`endif

   assign words_written_o    = ww_q;
   assign bus.snk_ready      = snk_ready;
   assign bus.mem_chipselect = mem_cs_q;
   assign bus.mem_write      = mem_we_q;
   assign bus.mem_address    = mem_addr_q;
   assign bus.mem_writedata  = mem_wdata_q;
   assign bus.mem_byteenable = '1;

endmodule
